freq_meas_ctrl: RTL
===================

// Module: freq_meas_ctrl
// PURPOSE
//  Sequencer for the equal-precision frequency counter. Arms the gate (single-shot or continuous) and
//  waits for the end-of-measurement flag. It then latches fs_cnt/fx_cnt, computes
//  freq = CLK_FS*fx_cnt/fs_cnt with a sequential divider, and delivers the result on a valid/ready port.
//  Sits between the counter core (sys_clk domain) and the host/display logic. Flags timeout and divide errors.
// PARAMETERS
//  CLK_FS      100_000_000  reference clock frequency in Hz (fits 28 bits)
//  TIMEOUT_CYC 200_000_000  sys_clk cycles allowed in WAIT_END before timeout (fits 32 bits)
//  CNT_W       32           width of fs_cnt/fx_cnt/freq_out
// PORTS
//  sys_clk        in   1      system/reference clock; only clock of the block
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      single-cycle pulse: begin one measurement (ignored unless IDLE)
//  continuous     in   1      sampled in HOLD after handshake: 1 = re-arm automatically
//  abort          in   1      pulse: return to IDLE from any state, result discarded
//  meas_en        out  1      enable to counter core; high only in ARM/WAIT_END
//  meas_end_flag  in   1      1-cycle pulse from core: fs_cnt/fx_cnt valid this cycle
//  fs_cnt         in   CNT_W  reference-clock count over gate
//  fx_cnt         in   CNT_W  input-clock count over gate
//  freq_out       out  CNT_W  measured frequency in Hz
//  freq_valid     out  1      freq_out valid; held until freq_ready
//  freq_ready     in   1      consumer accepts result
//  busy           out  1      state != IDLE
//  err_timeout    out  1      sticky; set on timeout, cleared by next accepted start
//  err_div        out  1      sticky; fs_cnt==0 or quotient overflow, cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; meas_en, freq_valid, busy, err_* = 0; freq_out=0; timeout counter=0.
//  FSM: IDLE -start-> ARM -> WAIT_END.
//    WAIT_END -meas_end_flag-> CALC.
//    WAIT_END -tmo-> IDLE, setting err_timeout.
//    CALC -div_done-> HOLD.
//    HOLD -freq_ready-> ARM if continuous, else IDLE.
//  ARM lasts exactly 1 cycle; it clears the timeout counter. meas_en=1 in ARM and WAIT_END.
//  WAIT_END: the counter increments each cycle. Timeout fires when the count reaches TIMEOUT_CYC-1 with no flag.
//    If the flag and timeout occur in the same cycle, the flag wins.
//  Capture: on the edge sampling meas_end_flag=1 in WAIT_END, latch fs_cnt and fx_cnt.
//    meas_end_flag outside WAIT_END is ignored.
//  Arithmetic: numerator N = CLK_FS(28b) * fx_cnt(32b), computed as a 64-bit unsigned product.
//    Quotient = floor(N/fs_cnt), 64-bit unsigned.
//  Divide-by-zero: if latched fs_cnt==0, skip the divider. Go to HOLD with freq_out = all-ones and err_div=1.
//  Overflow: if quotient[63:CNT_W] != 0, freq_out = all-ones (saturate) and err_div=1.
//  Latency: freq_valid rises exactly 66 sys_clk edges after the capture edge.
//    This is 1 load cycle + 64 divide iterations + 1 output register.
//    The divide-by-zero path rises 2 edges after capture.
//  Handshake: freq_valid and freq_out stay stable until the cycle with freq_valid&freq_ready.
//    freq_valid drops on the next edge. freq_ready while !freq_valid has no effect.
//  start while busy is ignored. start in the same cycle as an accepted handshake is ignored.
//  abort has priority over every transition: next state IDLE, meas_en=0, freq_valid=0. err_* are unchanged.
//  Async reset at any time returns all state to reset values. An in-flight divide is discarded.
// STRUCTURE
//  Shared package freq_meas_pkg holds:
//    state enum IDLE/ARM/WAIT_END/CALC/HOLD (3-bit encoding);
//    localparams DIV_ITER=64, DIV_LAT=66, default CLK_FS.
//  Sub-module freq_div_seq: 64/64 restoring shift-subtract divider, one quotient bit per cycle.
//    Ports: sys_clk, rst_n, div_start, dividend[63:0], divisor[63:0], div_done, quotient[63:0].
//  The top holds the FSM, timeout counter, capture registers, multiplier and output register.
// TESTING
//  1 fx_cnt=100, fs_cnt=1000, start pulse -> freq_out=10_000_000, freq_valid 66 edges after flag, err_*=0.
//  2 Hold freq_ready=0 for 20 cycles after valid -> freq_out/freq_valid stable; ready=1 -> valid drops next edge;
//    continuous=0 -> busy=0.
//  3 continuous=1, flag every 300 cycles, ready tied 1 -> three consecutive results;
//    meas_en re-asserts 1 cycle after each handshake.
//  4 TIMEOUT_CYC=50, no flag -> IDLE after 50 WAIT_END cycles, err_timeout=1, meas_en=0;
//    next start clears err_timeout.
//  5 fs_cnt=0 -> freq_out=32'hFFFF_FFFF, err_div=1, valid 2 edges after flag.
//    fx_cnt=32'hFFFF_FFFF, fs_cnt=1 -> saturated output, err_div=1.
//  6 abort mid-CALC and rst_n low mid-WAIT_END -> IDLE next edge / immediately.
//    No freq_valid pulse is produced. A flag arriving afterwards is ignored.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the equal-precision frequency counter sequencer.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_END = 3'd2,
    CALC     = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam int unsigned DIV_W      = 64;
  localparam int unsigned DIV_ITER   = 64;
  localparam int unsigned DIV_LAT    = 66;
  localparam int unsigned CLK_FS_DEF = 100_000_000;

endpackage

// File: rtl/freq_div_seq.sv
// 64/64 restoring shift-subtract divider; one quotient bit per cycle, div_done pulses with the result.
module freq_div_seq
  import freq_meas_pkg::*;
(
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             div_done,
  output logic [DIV_W-1:0] quotient
);

  localparam int unsigned ITER_W = $clog2(DIV_ITER + 1);

  logic [DIV_W-1:0]  rem;
  logic [DIV_W-1:0]  dvs;
  logic [ITER_W-1:0] iter;
  logic [DIV_W:0]    part_c;
  logic [DIV_W:0]    trial_c;
  logic              qbit_c;

  // Shift the next dividend bit into the remainder and try subtracting the divisor.
  always_comb begin
    part_c  = {rem, quotient[DIV_W-1]};
    trial_c = part_c - {1'b0, dvs};
    qbit_c  = ~trial_c[DIV_W];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      iter     <= '0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
        iter     <= ITER_W'(DIV_ITER);
      end else if (iter != '0) begin
        rem      <= qbit_c ? trial_c[DIV_W-1:0] : part_c[DIV_W-1:0];
        quotient <= {quotient[DIV_W-2:0], qbit_c};
        iter     <= iter - ITER_W'(1);
        div_done <= (iter == ITER_W'(1));
      end
    end
  end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: arms the counter core, captures counts, divides, and hands off the frequency.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_FS      = CLK_FS_DEF,
  parameter int unsigned TIMEOUT_CYC = 200_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             meas_en,
  input  logic             meas_end_flag,
  input  logic [CNT_W-1:0] fs_cnt,
  input  logic [CNT_W-1:0] fx_cnt,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  input  logic             freq_ready,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_div
);

  localparam int unsigned TMO_W = 32;

  state_t           state;
  state_t           state_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] fs_cap;
  logic [CNT_W-1:0] fx_cap;
  logic             div_go;
  logic             zero_done;
  logic             div_done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] dividend_c;
  logic [DIV_W-1:0] divisor_c;
  logic             flag_c;
  logic             tmo_c;
  logic             calc_done_c;
  logic             hs_c;
  logic             start_ok_c;
  logic             ovf_c;

  assign dividend_c  = DIV_W'(CLK_FS) * DIV_W'(fx_cap);
  assign divisor_c   = DIV_W'(fs_cap);
  assign flag_c      = (state == WAIT_END) && meas_end_flag;
  assign tmo_c       = (state == WAIT_END) && !meas_end_flag &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  // A done seen during the load cycle belongs to a discarded divide.
  assign calc_done_c = (state == CALC) && !div_go && (zero_done || div_done);
  assign hs_c        = (state == HOLD) && freq_valid && freq_ready;
  assign start_ok_c  = (state == IDLE) && start && !abort;
  assign ovf_c       = |quotient[DIV_W-1:CNT_W];

  freq_div_seq u_div (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .div_start (div_go),
    .dividend  (dividend_c),
    .divisor   (divisor_c),
    .div_done  (div_done),
    .quotient  (quotient)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = ARM;
      ARM:      state_d = WAIT_END;
      WAIT_END: begin
        if (meas_end_flag) state_d = CALC;
        else if (tmo_c)    state_d = IDLE;
      end
      CALC:     if (calc_done_c) state_d = HOLD;
      HOLD:     if (hs_c) state_d = continuous ? ARM : IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Datapath, status flags and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_en     <= 1'b0;
      busy        <= 1'b0;
      tmo_cnt     <= '0;
      fs_cap      <= '0;
      fx_cap      <= '0;
      div_go      <= 1'b0;
      zero_done   <= 1'b0;
      freq_out    <= '0;
      freq_valid  <= 1'b0;
      err_timeout <= 1'b0;
      err_div     <= 1'b0;
    end else begin
      meas_en   <= (state_d == ARM) || (state_d == WAIT_END);
      busy      <= (state_d != IDLE);
      div_go    <= flag_c && !abort;
      zero_done <= div_go && (fs_cap == '0) && !abort;

      if (state == ARM)           tmo_cnt <= '0;
      else if (state == WAIT_END) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (flag_c) begin
        fs_cap <= fs_cnt;
        fx_cap <= fx_cnt;
      end

      if (start_ok_c) begin
        err_timeout <= 1'b0;
        err_div     <= 1'b0;
      end else if (!abort) begin
        if (tmo_c) err_timeout <= 1'b1;
        if (calc_done_c && (zero_done || ovf_c)) err_div <= 1'b1;
      end

      if (calc_done_c && !abort) begin
        freq_out <= (zero_done || ovf_c) ? '1 : quotient[CNT_W-1:0];
      end

      if (abort)            freq_valid <= 1'b0;
      else if (calc_done_c) freq_valid <= 1'b1;
      else if (hs_c)        freq_valid <= 1'b0;
    end
  end

endmodule
